// File: rtl/result_packer.sv
// result_packer: buffers 24-bit compute results in a FIFO and packs them into
// 256-bit words of eight 32-bit lanes (lane 0 = bits [31:0]) for a
// valid/ready write port. A flush request emits any partially filled word,
// marked as last, and then pulses o_flush_done.
//
// Optional feature: define RESULT_PACKER_SIGN_EXT_EN to sign-extend bit 23
// of each result into lane bits [31:24]. Results are zero-extended when the
// macro is not defined.
//
// Output handshake: o_wr_valid rises only when a complete word, its lane
// mask and its last flag are loaded into the output register. Those values
// stay stable until the cycle where o_wr_valid and i_wr_ready are both high,
// and the word retires on that clock edge.
module result_packer #(
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [23:0]  i_result_data,
  input  logic         i_result_valid,
  output logic         o_result_full,
  output logic         o_result_afull,
  input  logic         i_flush,
  output logic [255:0] o_wr_data,
  output logic [7:0]   o_wr_lane_mask,
  output logic         o_wr_valid,
  input  logic         i_wr_ready,
  output logic         o_wr_last,
  output logic         o_flush_done,
  output logic [15:0]  o_result_count,
  output logic         o_drop_err,
  output logic [1:0]   o_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_V    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AFULL_TH_V = (AW+1)'(FIFO_DEPTH - AFULL_MARGIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_EMIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // Widen a raw result to a 32-bit lane.
  function automatic logic [31:0] ext_lane(input logic [23:0] d);
`ifdef RESULT_PACKER_SIGN_EXT_EN
    return {{8{d[23]}}, d};
`else
    return {8'h00, d};
`endif
  endfunction

  // FIFO storage and bookkeeping
  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q;
  logic [15:0]   count_q;
  logic          drop_q;

  // Packer state
  state_t          state_q;
  logic [7:0][31:0] lanes_q;
  logic [2:0]      lane_idx_q;
  logic            flush_pend_q;
  logic [255:0]    wr_data_q;
  logic [7:0]      wr_mask_q;
  logic            wr_valid_q;
  logic            wr_last_q;
  logic            flush_done_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [31:0] pop_lane;

  assign fifo_full  = (occ_q == DEPTH_V);
  assign fifo_empty = (occ_q == '0);
  // A write arriving while full is dropped even if a pop happens in the same cycle.
  assign push       = i_result_valid && !fifo_full;
  // Only the packing states consume results, and never while a word is held.
  assign pop        = !fifo_empty && !wr_valid_q &&
                      ((state_q == S_IDLE) || (state_q == S_PACK));
  assign pop_lane   = ext_lane(mem_q[rd_ptr_q]);

  // Result storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_result_data;
    end
  end

  // FIFO pointers, occupancy, accepted-result counter and sticky drop flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q  <= count_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      occ_q <= occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (i_result_valid && fifo_full) begin
        drop_q <= 1'b1;
      end
    end
  end

  // Packer FSM: fills lanes in FIFO order, emits full or flushed words.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      lanes_q      <= '0;
      lane_idx_q   <= '0;
      flush_pend_q <= 1'b0;
      wr_data_q    <= '0;
      wr_mask_q    <= '0;
      wr_valid_q   <= 1'b0;
      wr_last_q    <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_PACK: begin
          if (pop) begin
            if (lane_idx_q == 3'd7) begin
              // Last lane filled: move the whole word to the output register.
              wr_data_q  <= {pop_lane, lanes_q[6:0]};
              wr_mask_q  <= 8'hFF;
              wr_last_q  <= 1'b0;
              wr_valid_q <= 1'b1;
              lanes_q    <= '0;
              lane_idx_q <= '0;
              state_q    <= S_EMIT;
            end else begin
              lanes_q[lane_idx_q] <= pop_lane;
              lane_idx_q          <= lane_idx_q + 3'd1;
              state_q             <= S_PACK;
            end
          end else if (flush_pend_q && fifo_empty && !wr_valid_q) begin
            state_q <= S_FLUSH;
          end
        end
        S_EMIT: begin
          if (i_wr_ready) begin
            wr_valid_q <= 1'b0;
            if (wr_last_q) begin
              wr_last_q    <= 1'b0;
              flush_done_q <= 1'b1;
              flush_pend_q <= 1'b0;
              state_q      <= S_IDLE;
            end else if (fifo_empty && (lane_idx_q == 3'd0)) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_PACK;
            end
          end
        end
        S_FLUSH: begin
          if (lane_idx_q != 3'd0) begin
            wr_data_q  <= lanes_q;
            wr_mask_q  <= (8'd1 << lane_idx_q) - 8'd1;
            wr_last_q  <= 1'b1;
            wr_valid_q <= 1'b1;
            lanes_q    <= '0;
            lane_idx_q <= '0;
            state_q    <= S_EMIT;
          end else begin
            flush_done_q <= 1'b1;
            flush_pend_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A flush request is latched last so repeated requests merge into the pending one.
      if (i_flush) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

  assign o_result_full  = fifo_full;
  assign o_result_afull = (occ_q >= AFULL_TH_V);
  assign o_wr_data      = wr_data_q;
  assign o_wr_lane_mask = wr_mask_q;
  assign o_wr_valid     = wr_valid_q;
  assign o_wr_last      = wr_last_q;
  assign o_flush_done   = flush_done_q;
  assign o_result_count = count_q;
  assign o_drop_err     = drop_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_result_packer.sv
// Testbench for result_packer: scoreboard of expected output words
// ({last, mask, data}) built from driven results and flush requests.
module tb_result_packer;

  logic         i_clk;
  logic         i_reset_n;
  logic [23:0]  i_result_data;
  logic         i_result_valid;
  logic         o_result_full;
  logic         o_result_afull;
  logic         i_flush;
  logic [255:0] o_wr_data;
  logic [7:0]   o_wr_lane_mask;
  logic         o_wr_valid;
  logic         i_wr_ready;
  logic         o_wr_last;
  logic         o_flush_done;
  logic [15:0]  o_result_count;
  logic         o_drop_err;
  logic [1:0]   o_state;

  result_packer #(.FIFO_DEPTH(16), .AFULL_MARGIN(4)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_result_data  (i_result_data),
    .i_result_valid (i_result_valid),
    .o_result_full  (o_result_full),
    .o_result_afull (o_result_afull),
    .i_flush        (i_flush),
    .o_wr_data      (o_wr_data),
    .o_wr_lane_mask (o_wr_lane_mask),
    .o_wr_valid     (o_wr_valid),
    .i_wr_ready     (i_wr_ready),
    .o_wr_last      (o_wr_last),
    .o_flush_done   (o_flush_done),
    .o_result_count (o_result_count),
    .o_drop_err     (o_drop_err),
    .o_state        (o_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard state ----------------
  logic [264:0]     exp_q[$];
  logic [7:0][31:0] m_lanes;
  int               m_idx;
  int               exp_count;
  int               assert_cnt;
  int               fail_cnt;
  int               done_cnt;
  logic             done_due;
  logic             hold_vld;
  logic [264:0]     hold_word;

  task automatic check(input string tag, input logic [264:0] obs, input logic [264:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_ext(input logic [23:0] d);
`ifdef RESULT_PACKER_SIGN_EXT_EN
    return {{8{d[23]}}, d};
`else
    return {8'h00, d};
`endif
  endfunction

  task automatic model_write(input logic [23:0] d);
    m_lanes[m_idx] = model_ext(d);
    m_idx++;
    exp_count++;
    if (m_idx == 8) begin
      exp_q.push_back({1'b0, 8'hFF, m_lanes});
      m_lanes = '0;
      m_idx   = 0;
    end
  endtask

  task automatic model_flush();
    logic [7:0] mask;
    if (m_idx > 0) begin
      mask = 8'((1 << m_idx) - 1);
      exp_q.push_back({1'b1, mask, m_lanes});
    end
    m_lanes = '0;
    m_idx   = 0;
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic drive_write(input logic [23:0] d);
    i_result_data  = d;
    i_result_valid = 1'b1;
    @(posedge i_clk); #1;
    i_result_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_state != 2'd0 || o_wr_valid) && n < 2000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 2000) check("drain_timeout", 265'(n), 265'd0);
    cycles(3);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", 265'(o_wr_valid), 265'd0);
    check("rst_data", 265'(o_wr_data), 265'd0);
    check("rst_mask", 265'(o_wr_lane_mask), 265'd0);
    check("rst_last", 265'(o_wr_last), 265'd0);
    check("rst_done", 265'(o_flush_done), 265'd0);
    check("rst_full", 265'(o_result_full), 265'd0);
    check("rst_afull", 265'(o_result_afull), 265'd0);
    check("rst_count", 265'(o_result_count), 265'd0);
    check("rst_drop", 265'(o_drop_err), 265'd0);
    check("rst_state", 265'(o_state), 265'd0);
  endtask

  // ---------------- output monitor (negedge sampling) ----------------
  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      hold_vld = 1'b0;
      done_due = 1'b0;
    end else begin
      if (done_due) begin
        check("flush_done_pulse", 265'(o_flush_done), 265'd1);
        done_due = 1'b0;
      end
      if (o_flush_done) done_cnt++;
      if (hold_vld && o_wr_valid)
        check("hold_stable", {o_wr_last, o_wr_lane_mask, o_wr_data}, hold_word);
      hold_vld  = o_wr_valid && !i_wr_ready;
      hold_word = {o_wr_last, o_wr_lane_mask, o_wr_data};
      if (o_wr_valid && i_wr_ready) begin
        if (exp_q.size() == 0)
          check("unexpected_word", {o_wr_last, o_wr_lane_mask, o_wr_data}, 265'd0);
        else
          check("wr_word", {o_wr_last, o_wr_lane_mask, o_wr_data}, exp_q.pop_front());
        if (o_wr_last) done_due = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    logic [23:0] rd;
    assert_cnt = 0; fail_cnt = 0; done_cnt = 0; done_due = 1'b0;
    hold_vld = 1'b0; hold_word = '0;
    m_lanes = '0; m_idx = 0; exp_count = 0;
    i_reset_n = 1'b0; i_result_data = '0; i_result_valid = 1'b0;
    i_flush = 1'b0; i_wr_ready = 1'b1;
    cycles(3);
    check_reset_outputs();
    i_reset_n = 1'b1;
    cycles(2);

    // Eight results make one full word.
    for (int i = 1; i <= 8; i++) begin
      drive_write(24'(i));
      model_write(24'(i));
    end
    wait_drain();

    // Three results then flush: partial last word and a done pulse.
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      drive_write(24'h000011 + 24'(i));
      model_write(24'h000011 + 24'(i));
    end
    pulse_flush();
    model_flush();
    wait_drain();
    check("flush_done_cnt", 265'(done_cnt), 265'(d0 + 1));

    // Lane extension of a negative result.
    drive_write(24'h800000);
    model_write(24'h800000);
    pulse_flush();
    model_flush();
    wait_drain();

    // Flush with nothing pending: no word, one done pulse, back to IDLE.
    d0 = done_cnt;
    pulse_flush();
    model_flush();
    cycles(6);
    check("empty_flush_done", 265'(done_cnt), 265'(d0 + 1));
    check("empty_flush_state", 265'(o_state), 265'd0);

    // Back-pressure: fill word register and FIFO, then overflow.
    i_wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_write(24'h000100 + 24'(i));
      model_write(24'h000100 + 24'(i));
    end
    cycles(5);
    for (int k = 1; k <= 16; k++) begin
      drive_write(24'h000200 + 24'(k));
      model_write(24'h000200 + 24'(k));
      check("afull", 265'(o_result_afull), 265'(k >= 12));
      check("full", 265'(o_result_full), 265'(k == 16));
    end
    drive_write(24'h0000EE);
    check("drop_err", 265'(o_drop_err), 265'd1);
    check("count_after_drop", 265'(o_result_count), 265'(16'(exp_count)));
    i_wr_ready = 1'b1;
    wait_drain();
    check("full_cleared", 265'(o_result_full), 265'd0);

    // Random data with random back-pressure, then a flush.
    for (int i = 0; i < 20; i++) begin
      i_wr_ready = 1'($urandom_range(0, 1));
      rd = 24'($urandom_range(0, 24'hFFFFFF));
      drive_write(rd);
      model_write(rd);
    end
    pulse_flush();
    model_flush();
    i_wr_ready = 1'b1;
    wait_drain();
    check("count_random", 265'(o_result_count), 265'(16'(exp_count)));

    // Reset mid-operation with a held word and a partial word in flight.
    i_wr_ready = 1'b0;
    for (int i = 0; i < 9; i++) drive_write(24'h000300 + 24'(i));
    i_reset_n = 1'b0;
    cycles(2);
    check_reset_outputs();
    exp_q.delete();
    m_lanes = '0; m_idx = 0; exp_count = 0;
    i_reset_n = 1'b1;
    i_wr_ready = 1'b1;
    cycles(5);
    check("post_reset_no_word", 265'(o_wr_valid), 265'd0);
    for (int i = 0; i < 8; i++) begin
      drive_write(24'h000400 + 24'(i));
      model_write(24'h000400 + 24'(i));
    end
    wait_drain();
    check("post_reset_count", 265'(o_result_count), 265'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
